// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID record type for the fetch front end.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 16;
  localparam int unsigned DEF_INSTR_WIDTH = 16;
  localparam int unsigned DEF_IMEM_DEPTH  = 256;

  localparam logic [DEF_INSTR_WIDTH-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]  pc;
    logic [DEF_ADDR_WIDTH-1:0]  next_pc;
    logic [DEF_INSTR_WIDTH-1:0] instr;
    logic                       valid;
  } ifid_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Control, program-load and IF/ID signals between the fetch unit and the rest of the core.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 16
);

  logic                   stall_i;
  logic                   flush_i;
  logic                   branch_taken_i;
  logic [ADDR_WIDTH-1:0]  branch_target_i;
  logic                   imem_we_i;
  logic [ADDR_WIDTH-1:0]  imem_waddr_i;
  logic [INSTR_WIDTH-1:0] imem_wdata_i;

  logic [ADDR_WIDTH-1:0]  pc_o;
  logic [ADDR_WIDTH-1:0]  id_pc_o;
  logic [ADDR_WIDTH-1:0]  next_pc_o;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic                   valid_o;

  modport master (
    output stall_i, flush_i, branch_taken_i, branch_target_i,
           imem_we_i, imem_waddr_i, imem_wdata_i,
    input  pc_o, id_pc_o, next_pc_o, instr_o, valid_o
  );

  modport slave (
    input  stall_i, flush_i, branch_taken_i, branch_target_i,
           imem_we_i, imem_waddr_i, imem_wdata_i,
    output pc_o, id_pc_o, next_pc_o, instr_o, valid_o
  );

endinterface

// File: rtl/fetch_imem.sv
// Instruction memory: combinational read, synchronous write, zero power-up contents, never reset.
module fetch_imem #(
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned IMEM_AW     = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk_i,
  input  logic [IMEM_AW-1:0]     raddr,
  output logic [INSTR_WIDTH-1:0] rdata,
  input  logic                   we,
  input  logic [IMEM_AW-1:0]     waddr,
  input  logic [INSTR_WIDTH-1:0] wdata
);

  logic [INSTR_WIDTH-1:0] mem [IMEM_DEPTH] = '{default: '0};

  // Read-before-write: a same-edge fetch of the written word returns the old data.
  assign rdata = mem[raddr];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, instruction memory and the IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds a 32-bit fetch_count_o capture counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned IMEM_DEPTH  = DEF_IMEM_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.slave  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_count_o
`endif
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  next_pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   valid;
  } ifid_rec_t;

  localparam ifid_rec_t BUBBLE = '{
    pc:      '0,
    next_pc: '0,
    instr:   INSTR_WIDTH'(NOP_INSTR),
    valid:   1'b0
  };

  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_inc;
  logic [INSTR_WIDTH-1:0] fetch_word;
  ifid_rec_t              ifid_q;
  logic                   kill;
  logic                   capture;
  logic                   unused_waddr_bits;

  assign pc_inc  = pc_q + ADDR_WIDTH'(1);
  assign kill    = bus.flush_i | bus.branch_taken_i;
  assign capture = ~kill & ~bus.stall_i;

  // Only the low address bits index the memory; the rest are ignored.
  assign unused_waddr_bits = ^bus.imem_waddr_i;

  fetch_imem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .IMEM_DEPTH  (IMEM_DEPTH),
    .IMEM_AW     (IMEM_AW)
  ) u_imem (
    .clk_i (clk_i),
    .raddr (pc_q[IMEM_AW-1:0]),
    .rdata (fetch_word),
    .we    (bus.imem_we_i),
    .waddr (bus.imem_waddr_i[IMEM_AW-1:0]),
    .wdata (bus.imem_wdata_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else if (bus.branch_taken_i) begin
      pc_q <= bus.branch_target_i;
    end else if (!bus.stall_i) begin
      pc_q <= pc_inc;
    end
  end

  // Flush/branch outranks stall, so a stalled stage can still be bubbled.
  always_ff @(posedge clk_i) begin
    if (rst_i || kill) begin
      ifid_q <= BUBBLE;
    end else if (capture) begin
      ifid_q.pc      <= pc_q;
      ifid_q.next_pc <= pc_inc;
      ifid_q.instr   <= fetch_word;
      ifid_q.valid   <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
    end else if (capture) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
`endif

  assign bus.pc_o      = pc_q;
  assign bus.id_pc_o   = ifid_q.pc;
  assign bus.next_pc_o = ifid_q.next_pc;
  assign bus.instr_o   = ifid_q.instr;
  assign bus.valid_o   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, then randomized traffic against a reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_unit #(
    .ADDR_WIDTH  (16),
    .INSTR_WIDTH (16),
    .IMEM_DEPTH  (256)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_o (fetch_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain integers and an array for the memory.
  int unsigned m_pc;
  ifid_t       m_ifid;
  logic [15:0] m_mem [256];
  int unsigned m_cnt;

  typedef struct {
    logic        rst, stall, flush, br;
    logic [15:0] tgt;
    logic        we;
    logic [15:0] wa, wd;
    logic [15:0] e_pc, e_id, e_npc, e_instr;
    logic        e_v;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, st, fl, br, input logic [15:0] tgt,
                              input logic we, input logic [15:0] wa, wd,
                              input logic [15:0] e_pc, e_id, e_npc, e_instr,
                              input logic e_v);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.br = br; v.tgt = tgt;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e_pc = e_pc; v.e_id = e_id; v.e_npc = e_npc; v.e_instr = e_instr; v.e_v = e_v;
    tbl.push_back(v);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp_v, $time);
    end
  endfunction

  task automatic drive(input logic r, st, fl, br, input logic [15:0] tgt,
                       input logic we, input logic [15:0] wa, wd);
    rst                 = r;
    bus.stall_i         = st;
    bus.flush_i         = fl;
    bus.branch_taken_i  = br;
    bus.branch_target_i = tgt;
    bus.imem_we_i       = we;
    bus.imem_waddr_i    = wa;
    bus.imem_wdata_i    = wd;
  endtask

  // One clock edge of the specified behaviour, using the currently driven inputs.
  task automatic model_edge();
    logic [15:0] rd;
    rd = m_mem[m_pc % 256];
    if (rst) begin
      m_pc   = 0;
      m_ifid = '0;
      m_cnt  = 0;
    end else begin
      if (bus.flush_i || bus.branch_taken_i) begin
        m_ifid = '0;
      end else if (!bus.stall_i) begin
        m_ifid.instr   = rd;
        m_ifid.pc      = 16'(m_pc);
        m_ifid.next_pc = 16'((m_pc + 1) % 65536);
        m_ifid.valid   = 1'b1;
        m_cnt          = m_cnt + 1;
      end
      if (bus.branch_taken_i)  m_pc = int'(bus.branch_target_i);
      else if (!bus.stall_i)   m_pc = (m_pc + 1) % 65536;
    end
    if (bus.imem_we_i) m_mem[bus.imem_waddr_i % 256] = bus.imem_wdata_i;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count();
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  initial begin
    m_pc = 0;
    m_ifid = '0;
    m_cnt = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    // rst st fl br tgt  we wa wd      | pc id npc instr v
    add(1,0,0,0,16'h0000, 1,16'h0000,16'h1111, 16'h0000,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0,0,16'h0000, 1,16'h0001,16'h2222, 16'h0000,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0,0,16'h0000, 1,16'h0002,16'h3333, 16'h0000,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0,0,16'h0000, 1,16'h0003,16'h4444, 16'h0000,16'h0000,16'h0000,16'h0000,0);
    add(1,0,0,0,16'h0000, 1,16'h0040,16'hBEEF, 16'h0000,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0001,16'h0000,16'h0001,16'h1111,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0002,16'h0001,16'h0002,16'h2222,1);
    add(0,1,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0002,16'h0001,16'h0002,16'h2222,1);
    add(0,1,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0002,16'h0001,16'h0002,16'h2222,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0003,16'h0002,16'h0003,16'h3333,1);
    add(0,0,0,1,16'h0040, 0,16'h0000,16'h0000, 16'h0040,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0041,16'h0040,16'h0041,16'hBEEF,1);
    add(0,1,1,0,16'h0000, 0,16'h0000,16'h0000, 16'h0041,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0042,16'h0041,16'h0042,16'h0000,1);
    add(0,0,0,1,16'hFFFF, 0,16'h0000,16'h0000, 16'hFFFF,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0000,16'hFFFF,16'h0000,16'h0000,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0001,16'h0000,16'h0001,16'h1111,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0002,16'h0001,16'h0002,16'h2222,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0003,16'h0002,16'h0003,16'h3333,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0004,16'h0003,16'h0004,16'h4444,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0005,16'h0004,16'h0005,16'h0000,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0006,16'h0005,16'h0006,16'h0000,1);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0007,16'h0006,16'h0007,16'h0000,1);
    add(1,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0001,16'h0000,16'h0001,16'h1111,1);
    // Same-edge write to the fetched word: old data captured, new data seen after re-fetch.
    add(0,0,0,0,16'h0000, 1,16'h0001,16'h5555, 16'h0002,16'h0001,16'h0002,16'h2222,1);
    add(0,0,0,1,16'h0001, 0,16'h0000,16'h0000, 16'h0001,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0002,16'h0001,16'h0002,16'h5555,1);
    add(0,1,0,1,16'h0010, 0,16'h0000,16'h0000, 16'h0010,16'h0000,16'h0000,16'h0000,0);
    add(0,0,0,0,16'h0000, 0,16'h0000,16'h0000, 16'h0011,16'h0010,16'h0011,16'h0000,1);

    drive(1, 0, 0, 0, '0, 0, '0, '0);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].br, tbl[i].tgt,
            tbl[i].we, tbl[i].wa, tbl[i].wd);
      cycle();
      chk($sformatf("vec%0d.pc", i),    bus.pc_o,      tbl[i].e_pc);
      chk($sformatf("vec%0d.id_pc", i), bus.id_pc_o,   tbl[i].e_id);
      chk($sformatf("vec%0d.npc", i),   bus.next_pc_o, tbl[i].e_npc);
      chk($sformatf("vec%0d.instr", i), bus.instr_o,   tbl[i].e_instr);
      chk($sformatf("vec%0d.valid", i), bus.valid_o,   tbl[i].e_v);
      check_count();
    end

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            tgt,
            $urandom_range(0, 3) == 0,
            16'($urandom),
            16'($urandom));
      cycle();
      chk("rnd.pc",    bus.pc_o,      m_pc);
      chk("rnd.id_pc", bus.id_pc_o,   m_ifid.pc);
      chk("rnd.npc",   bus.next_pc_o, m_ifid.next_pc);
      chk("rnd.instr", bus.instr_o,   m_ifid.instr);
      chk("rnd.valid", bus.valid_o,   m_ifid.valid);
      check_count();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
